sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, parametrised synchronous FIFO: the single-domain successor to the dual-clock FIFO storage used in the pipelined CPU. It adds occupancy count, programmable almost-full/almost-empty flags, synchronous flush and a registered read-valid strobe. It buffers between pipeline stages that share `clk`, such as the fetch queue and the store buffer.

## Interface
- `DATA_WIDTH`, 32, word width in bits.
- `DEPTH`, 32, entries; power of two, ≥ 4.
- `ADDR_WIDTH`, `$clog2(DEPTH)`, index width (derived; do not override).
- `AF_THRESH`, `DEPTH-4`, `almost_full` asserts when count ≥ AF_THRESH.
- `AE_THRESH`, 4, `almost_empty` asserts when count ≤ AE_THRESH.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear of FIFO state.
- `w_en`  in  1  write request.
- `w_data`  in  DATA_WIDTH  write data.
- `r_en`  in  1  read request.
- `r_data`  out  DATA_WIDTH  registered read data.
- `r_valid`  out  1  `r_data` updated by a read accepted the previous cycle.
- `full`, `empty`  out  1  occupancy flags (combinational from registered pointers).
- `almost_full`, `almost_empty`  out  1  threshold flags.
- `count`  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- `overflow`, `underflow`  out  1  sticky error flags (only with `SYNC_FIFO_ERR_EN`).

## Operation
- Pointers `wptr`/`rptr` are ADDR_WIDTH+1 bits; the low ADDR_WIDTH bits index memory and the MSB is the wrap bit.
- `empty` = pointers equal. `full` = MSBs differ and low bits equal. `count` = `wptr - rptr` (modulo 2^(ADDR_WIDTH+1)).
- Write accepted iff `w_en && !full && !flush`: mem[wptr] ← w_data, wptr+1.
- Read accepted iff `r_en && !empty && !flush`: r_data ← mem[rptr], rptr+1, r_valid=1 next cycle; otherwise r_valid=0 and r_data holds its value.
- Full and empty are evaluated on the current-cycle state:
  - Full with simultaneous w_en and r_en: the read is accepted, the write is rejected, and the FIFO drops to DEPTH-1.
  - Empty with simultaneous w_en and r_en: the write is accepted, the read is rejected, and count goes to 1.
  - Neither full nor empty: both are accepted and count is unchanged.
- Wrap-around: pointer increments roll over naturally. No special-casing.
- `flush` takes priority over w_en/r_en. It zeroes the pointers, r_valid and (if compiled) the error flags. r_data and memory contents are unchanged.
- Memory array is never reset.

## Timing
- Reset values: r_data=0, r_valid=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0 (for AF_THRESH>0), overflow=underflow=0.
- Read latency: 1 cycle from accepted r_en to r_data/r_valid.
- Write-to-read: a word written in cycle N is readable (empty=0) in cycle N+1, so data is out at N+2 at the earliest.
- Flags and count reflect all accesses accepted on the previous edge. There is no combinational path from w_en/r_en to the flags.
- resetn assertion mid-operation clears state immediately, independent of clk. Deassertion is assumed synchronised externally.

## Configuration
- `SYNC_FIFO_ERR_EN` defined: the `overflow` and `underflow` ports exist.
  - overflow sets on `w_en && full && !flush`.
  - underflow sets on `r_en && empty && !flush`.
  - Both stay set until resetn or flush.
- `SYNC_FIFO_ERR_EN` undefined: both ports and their registers are absent. Rejected requests are silently dropped.

## Structure
- Shared package `fifo_pkg`: a `ptr_t` helper function, the full/empty compare functions, and defaults for DEPTH, AF_THRESH and AE_THRESH.
- Sub-module `sync_fifo_mem`: single-clock simple dual-port array (one write port, one registered read port, read-enable gated), DATA_WIDTH × DEPTH.
- Top level holds pointers, flags, count and error logic.

## Test plan
- Reset, then 32 writes of 0..31 with no reads → full=1 and count=32 after the last edge. almost_full first asserts at count=28. A 33rd write leaves count at 32 and, with ERR_EN, sets overflow=1.
- Drain the full FIFO with 32 back-to-back reads → r_data sequence 0..31, one cycle after each r_en, with r_valid=1. almost_empty asserts at count=4. empty=1 at the end. An extra read gives r_valid=0 and, with ERR_EN, sets underflow.
- Simultaneous w_en/r_en:
  - When full: count 32→31 and the written word is absent.
  - When empty: count 0→1 and r_valid=0.
  - At count=10: count stays 10 for 20 cycles.
- Wrap-around: 3× (write 20, read 20) with incrementing data → the read-out sequence is contiguous and the pointers wrap without data loss.
- Flush at count=17 with w_en=r_en=1 → next cycle count=0, empty=1, r_valid=0, r_data unchanged, error flags cleared.
- Assert resetn low asynchronously mid-burst (count=9) → outputs take their reset values before the next clk edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: wrap-bit pointer arithmetic, full/empty compares and
// default sizing used by sync_fifo.
package fifo_pkg;

   localparam int DEF_DEPTH     = 32;
   localparam int DEF_AF_THRESH = DEF_DEPTH - 4;
   localparam int DEF_AE_THRESH = 4;

   typedef logic [31:0] ptr_t;

   // Pointers carry one wrap bit above the index, so the increment rolls over at 2^(aw+1).
   function automatic ptr_t ptr_next(input ptr_t p, input int aw);
      ptr_t mask;
      mask = (ptr_t'(1) << (aw + 1)) - ptr_t'(1);
      return (p + ptr_t'(1)) & mask;
   endfunction

   function automatic logic ptr_empty(input ptr_t wp, input ptr_t rp);
      return wp == rp;
   endfunction

   function automatic logic ptr_full(input ptr_t wp, input ptr_t rp, input int aw);
      return (wp ^ rp) == (ptr_t'(1) << aw);
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Single-clock simple dual-port storage for sync_fifo: one write port and one
// registered, enable-gated read port. The array itself is never reset.
module sync_fifo_mem #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 32,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  i_wr_en,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_rd_en,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd_data
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_rd_data;

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // Read register holds its value whenever no read is accepted.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rd_data <= '0;
      end else if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, threshold flags, synchronous flush and
// registered read-valid. Optional sticky overflow/underflow flags: SYNC_FIFO_ERR_EN.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int AF_THRESH  = DEPTH - (DEF_DEPTH - DEF_AF_THRESH),
   parameter int AE_THRESH  = DEF_AE_THRESH
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  flush,
   input  logic                  w_en,
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic                  r_en,
   output logic [DATA_WIDTH-1:0] r_data,
   output logic                  r_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count
`ifdef SYNC_FIFO_ERR_EN
   ,
   output logic                  overflow,
   output logic                  underflow
`endif
);

   localparam logic [ADDR_WIDTH:0] AF_LEVEL = AF_THRESH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AE_LEVEL = AE_THRESH[ADDR_WIDTH:0];

   logic [ADDR_WIDTH:0] r_wptr;
   logic [ADDR_WIDTH:0] r_rptr;
   ptr_t                w_wptr_next;
   ptr_t                w_rptr_next;
   logic                w_wr_ok;
   logic                w_rd_ok;

   // Flags depend only on the registered pointers, never on this cycle's requests.
   assign empty        = ptr_empty(ptr_t'(r_wptr), ptr_t'(r_rptr));
   assign full         = ptr_full(ptr_t'(r_wptr), ptr_t'(r_rptr), ADDR_WIDTH);
   assign count        = r_wptr - r_rptr;
   assign almost_full  = count >= AF_LEVEL;
   assign almost_empty = count <= AE_LEVEL;

   assign w_wr_ok     = w_en && !full && !flush;
   assign w_rd_ok     = r_en && !empty && !flush;
   assign w_wptr_next = ptr_next(ptr_t'(r_wptr), ADDR_WIDTH);
   assign w_rptr_next = ptr_next(ptr_t'(r_rptr), ADDR_WIDTH);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_valid <= 1'b0;
      end else if (flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_valid <= 1'b0;
      end else begin
         if (w_wr_ok) begin
            r_wptr <= w_wptr_next[ADDR_WIDTH:0];
         end
         if (w_rd_ok) begin
            r_rptr <= w_rptr_next[ADDR_WIDTH:0];
         end
         r_valid <= w_rd_ok;
      end
   end

`ifdef SYNC_FIFO_ERR_EN
   logic r_overflow;
   logic r_underflow;

   // Sticky until reset or flush; a flushing cycle never counts as an error.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (flush) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_en && full) begin
            r_overflow <= 1'b1;
         end
         if (r_en && empty) begin
            r_underflow <= 1'b1;
         end
      end
   end

   assign overflow  = r_overflow;
   assign underflow = r_underflow;
`endif

   sync_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk       (clk),
      .resetn    (resetn),
      .i_wr_en   (w_wr_ok),
      .i_wr_addr (r_wptr[ADDR_WIDTH-1:0]),
      .i_wr_data (w_data),
      .i_rd_en   (w_rd_ok),
      .i_rd_addr (r_rptr[ADDR_WIDTH-1:0]),
      .o_rd_data (r_data)
   );

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios plus a random phase,
// compared each cycle against a queue-based reference model.
module tb_sync_fifo;

   localparam int DW    = 32;
   localparam int DEPTH = 32;
   localparam int AW    = 5;
   localparam int AF    = DEPTH - 4;
   localparam int AE    = 4;

   logic          clk;
   logic          resetn;
   logic          flush;
   logic          w_en;
   logic [DW-1:0] w_data;
   logic          r_en;
   logic [DW-1:0] r_data;
   logic          r_valid;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic [AW:0]   count;
`ifdef SYNC_FIFO_ERR_EN
   logic          overflow;
   logic          underflow;
`endif

   int vectors;
   int miscompares;

   logic [DW-1:0] mq[$];
   logic [DW-1:0] mRData;
   logic          mRValid;
`ifdef SYNC_FIFO_ERR_EN
   logic          mOvf;
   logic          mUdf;
`endif

   sync_fifo #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .flush        (flush),
      .w_en         (w_en),
      .w_data       (w_data),
      .r_en         (r_en),
      .r_data       (r_data),
      .r_valid      (r_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count)
`ifdef SYNC_FIFO_ERR_EN
      ,
      .overflow     (overflow),
      .underflow    (underflow)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic resetModel();
      mq.delete();
      mRData  = '0;
      mRValid = 1'b0;
`ifdef SYNC_FIFO_ERR_EN
      mOvf = 1'b0;
      mUdf = 1'b0;
`endif
   endtask

   task automatic checkOutput();
      check("count",        32'(count),        32'(mq.size()));
      check("full",         32'(full),         32'(mq.size() == DEPTH));
      check("empty",        32'(empty),        32'(mq.size() == 0));
      check("almost_full",  32'(almost_full),  32'(mq.size() >= AF));
      check("almost_empty", 32'(almost_empty), 32'(mq.size() <= AE));
      check("r_valid",      32'(r_valid),      32'(mRValid));
      check("r_data",       r_data,            mRData);
`ifdef SYNC_FIFO_ERR_EN
      check("overflow",     32'(overflow),     32'(mOvf));
      check("underflow",    32'(underflow),    32'(mUdf));
`endif
   endtask

   // Drive one cycle of requests from a falling edge, advance the model at the
   // rising edge, then compare on the next falling edge.
   task automatic applyStimulus(input logic we, input logic [DW-1:0] wd,
                                input logic re, input logic fl);
      logic mFull;
      logic mEmpty;
      w_en   = we;
      w_data = wd;
      r_en   = re;
      flush  = fl;
      mFull  = (mq.size() == DEPTH);
      mEmpty = (mq.size() == 0);
      @(posedge clk);
      if (fl) begin
         mq.delete();
         mRValid = 1'b0;
`ifdef SYNC_FIFO_ERR_EN
         mOvf = 1'b0;
         mUdf = 1'b0;
`endif
      end else begin
`ifdef SYNC_FIFO_ERR_EN
         if (we && mFull) mOvf = 1'b1;
         if (re && mEmpty) mUdf = 1'b1;
`endif
         mRValid = re && !mEmpty;
         if (mRValid) mRData = mq.pop_front();
         if (we && !mFull) mq.push_back(wd);
      end
      @(negedge clk);
      w_en  = 1'b0;
      r_en  = 1'b0;
      flush = 1'b0;
      checkOutput();
   endtask

   initial begin
      int seq;
      vectors     = 0;
      miscompares = 0;
      resetn      = 1'b0;
      flush       = 1'b0;
      w_en        = 1'b0;
      r_en        = 1'b0;
      w_data      = '0;
      resetModel();
      repeat (2) @(negedge clk);
      checkOutput();
      resetn = 1'b1;

      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 32'(i), 1'b0, 1'b0);
      applyStimulus(1'b1, 32'hBAD0_0001, 1'b0, 1'b0);
      for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

      applyStimulus(1'b1, 32'hA5A5_0000, 1'b1, 1'b0);
      for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1'b1, $urandom(), 1'b0, 1'b0);
      applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
      for (int i = 0; i < 14; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
      applyStimulus(1'b1, $urandom(), 1'b1, 1'b1);

      for (int i = 0; i < 10; i++) applyStimulus(1'b1, $urandom(), 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, $urandom(), 1'b1, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);

      seq = 1000;
      for (int round = 0; round < 3; round++) begin
         for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 32'(seq), 1'b0, 1'b0);
            seq++;
         end
         for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
      end

      for (int i = 0; i < 9; i++) applyStimulus(1'b1, $urandom(), 1'b0, 1'b0);
      w_en   = 1'b1;
      w_data = $urandom();
      #2;
      resetn = 1'b0;
      resetModel();
      #1;
      checkOutput();
      w_en = 1'b0;
      @(negedge clk);
      resetn = 1'b1;

      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom_range(0, 2) != 0), $urandom(),
                       1'($urandom_range(0, 2) != 0),
                       1'($urandom_range(0, 39) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
